// File: rtl/panel_arbiter.sv
// panel_arbiter
//   Shares the four front-panel buttons (mode, set, up, down) among the time
//   setter, alarm setter and stopwatch. Tracks the active mode, turns button
//   press edges into one-cycle command pulses routed to the owner of the
//   current mode, blocks mode changes while a setter is mid-sequence and
//   aborts or leaves abandoned setting sequences after an inactivity timeout.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   tick                  one-cycle timebase enable
//   btn_mode/set/up/down  debounced button levels (1 = pressed)
//   ts_state, al_state    setter states, 0 = idle
//   mode                  0 DISPLAY, 1 TIME, 2 ALARM, 3 STOPWATCH
//   ts_*/al_*/sw_*        one-cycle command pulses
//   locked                current mode's setter is busy (registered)
//
// Configuration
//   PANEL_ARBITER_AUTO_REPEAT_EN  builds the up/down hold counter and
//   auto-repeat; without it up/down give only edge pulses.

module panel_arbiter #(
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10,
  parameter int unsigned TIMEOUT      = 1000,
  parameter int unsigned CNT_W        = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [1:0] ts_state,
  input  logic [1:0] al_state,
  output logic [1:0] mode,
  output logic       ts_set,
  output logic       ts_up,
  output logic       ts_down,
  output logic       ts_abort,
  output logic       al_set,
  output logic       al_up,
  output logic       al_down,
  output logic       al_abort,
  output logic       sw_startstop,
  output logic       sw_lap,
  output logic       sw_clear,
  output logic       locked
);

  typedef enum logic [1:0] {
    MODE_DISPLAY   = 2'd0,
    MODE_TIME      = 2'd1,
    MODE_ALARM     = 2'd2,
    MODE_STOPWATCH = 2'd3
  } mode_e;

  // Bit positions inside the command pulse vector
  localparam int unsigned C_TS_SET  = 10;
  localparam int unsigned C_TS_UP   = 9;
  localparam int unsigned C_TS_DOWN = 8;
  localparam int unsigned C_TS_ABT  = 7;
  localparam int unsigned C_AL_SET  = 6;
  localparam int unsigned C_AL_UP   = 5;
  localparam int unsigned C_AL_DOWN = 4;
  localparam int unsigned C_AL_ABT  = 3;
  localparam int unsigned C_SW_SS   = 2;
  localparam int unsigned C_SW_LAP  = 1;
  localparam int unsigned C_SW_CLR  = 0;

  mode_e              mode_q, mode_d;
  logic [3:0]         prev_q;           // {mode, set, up, down}
  logic [10:0]        cmd_q, cmd_d;
  logic               locked_q;
  logic [CNT_W-1:0]   act_q, act_d;

  logic ev_mode, ev_set, ev_up, ev_down, any_ev;
  logic in_setter, locked_c;
  logic rep_pulse, rep_up;

`ifdef PANEL_ARBITER_AUTO_REPEAT_EN
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic               rep_q, rep_d;     // first repeat already issued
  logic               held_one;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  always_comb begin
    ev_mode   = btn_mode & ~prev_q[3];
    ev_set    = btn_set  & ~prev_q[2];
    ev_up     = btn_up   & ~prev_q[1];
    ev_down   = btn_down & ~prev_q[0];
    any_ev    = ev_mode | ev_set | ev_up | ev_down;
    in_setter = (mode_q == MODE_TIME) || (mode_q == MODE_ALARM);
    locked_c  = ((mode_q == MODE_TIME)  && (ts_state != 2'd0)) ||
                ((mode_q == MODE_ALARM) && (al_state != 2'd0));

    mode_d    = mode_q;
    cmd_d     = '0;
    act_d     = act_q;
    rep_pulse = 1'b0;
    rep_up    = 1'b0;

`ifdef PANEL_ARBITER_AUTO_REPEAT_EN
    hold_d   = hold_q;
    rep_d    = rep_q;
    // Exactly one of up/down held; holding both suppresses repeats.
    held_one = in_setter && (btn_up ^ btn_down);
    // Any press restarts the hold; the press cycle itself never ticks the counter.
    if (any_ev || !held_one) begin
      hold_d = '0;
      rep_d  = 1'b0;
    end else if (tick) begin
      if ((hold_q + CNT_W'(1)) == (rep_q ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY))) begin
        rep_pulse = 1'b1;
        hold_d    = '0;
        rep_d     = 1'b1;
      end else begin
        hold_d = hold_q + CNT_W'(1);
      end
    end
    rep_up = btn_up;
`endif

    // Only the highest-priority event acts; lower ones are dropped.
    if (ev_mode) begin
      if (!locked_c) begin
        case (mode_q)
          MODE_DISPLAY: mode_d = MODE_TIME;
          MODE_TIME:    mode_d = MODE_ALARM;
          MODE_ALARM:   mode_d = MODE_STOPWATCH;
          default:      mode_d = MODE_DISPLAY;
        endcase
      end
    end else if (ev_set) begin
      case (mode_q)
        MODE_TIME:      cmd_d[C_TS_SET] = 1'b1;
        MODE_ALARM:     cmd_d[C_AL_SET] = 1'b1;
        MODE_STOPWATCH: cmd_d[C_SW_SS]  = 1'b1;
        default:        ;
      endcase
    end else if (ev_up) begin
      case (mode_q)
        MODE_TIME:      cmd_d[C_TS_UP]  = 1'b1;
        MODE_ALARM:     cmd_d[C_AL_UP]  = 1'b1;
        MODE_STOPWATCH: cmd_d[C_SW_LAP] = 1'b1;
        default:        ;
      endcase
    end else if (ev_down) begin
      case (mode_q)
        MODE_TIME:      cmd_d[C_TS_DOWN] = 1'b1;
        MODE_ALARM:     cmd_d[C_AL_DOWN] = 1'b1;
        MODE_STOPWATCH: cmd_d[C_SW_CLR]  = 1'b1;
        default:        ;
      endcase
    end else if (rep_pulse) begin
      if (mode_q == MODE_TIME) begin
        cmd_d[rep_up ? C_TS_UP : C_TS_DOWN] = 1'b1;
      end else begin
        cmd_d[rep_up ? C_AL_UP : C_AL_DOWN] = 1'b1;
      end
    end

    // Activity timer: acts only in setter modes; elsewhere it just saturates.
    if (any_ev || rep_pulse) begin
      act_d = '0;
    end else if (act_q == CNT_W'(TIMEOUT)) begin
      if (locked_c) begin
        if (mode_q == MODE_TIME) cmd_d[C_TS_ABT] = 1'b1;
        else                     cmd_d[C_AL_ABT] = 1'b1;
        act_d = '0;
      end else if (in_setter) begin
        mode_d = MODE_DISPLAY;
        act_d  = '0;
      end
    end else if (tick) begin
      act_d = act_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= MODE_DISPLAY;
      prev_q   <= '0;
      cmd_q    <= '0;
      locked_q <= 1'b0;
      act_q    <= '0;
`ifdef PANEL_ARBITER_AUTO_REPEAT_EN
      hold_q   <= '0;
      rep_q    <= 1'b0;
`endif
    end else begin
      mode_q   <= mode_d;
      prev_q   <= {btn_mode, btn_set, btn_up, btn_down};
      cmd_q    <= cmd_d;
      locked_q <= locked_c;
      act_q    <= act_d;
`ifdef PANEL_ARBITER_AUTO_REPEAT_EN
      hold_q   <= hold_d;
      rep_q    <= rep_d;
`endif
    end
  end

  assign mode         = mode_q;
  assign locked       = locked_q;
  assign ts_set       = cmd_q[C_TS_SET];
  assign ts_up        = cmd_q[C_TS_UP];
  assign ts_down      = cmd_q[C_TS_DOWN];
  assign ts_abort     = cmd_q[C_TS_ABT];
  assign al_set       = cmd_q[C_AL_SET];
  assign al_up        = cmd_q[C_AL_UP];
  assign al_down      = cmd_q[C_AL_DOWN];
  assign al_abort     = cmd_q[C_AL_ABT];
  assign sw_startstop = cmd_q[C_SW_SS];
  assign sw_lap       = cmd_q[C_SW_LAP];
  assign sw_clear     = cmd_q[C_SW_CLR];

endmodule
